dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipelined core's data-memory port.
- Accepts load/store requests from the core's MEM stage over a valid/ready handshake and services them after a configurable number of wait states.
- Returns sign/zero-extended load data with a single-cycle response pulse.
- Replaces the zero-latency combinational data memory, so the core can be tested against realistic multi-cycle memory.

Parameters:
- ADDR_W, 8: byte-address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 32: data word width.
- WAIT_CYCLES, 2: wait states between accept and response; 0 is legal.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, synchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_addr, input, ADDR_W: byte address.
- req_read, input, 3: load type. 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- req_write, input, 2: store type. 0 none, 1 SB, 2 SH, 3 SW.
- req_wdata, input, DATA_W: store data, taken from the low bytes.
- resp_valid, output, 1: one-cycle completion pulse.
- resp_rdata, output, DATA_W: load result; valid only while resp_valid is high.
- resp_err, output, 1: misaligned-access flag, qualified by resp_valid.
- busy, output, 1: transaction in flight.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, wait counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - All memory bytes cleared to 0.
  - req_ready=0 while rst=0.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. Accept on req_valid=1 with req_read!=0 or req_write!=0. Latch addr, type and wdata; busy=1. Go to WAIT, or to RESP if WAIT_CYCLES=0.
  - A req_valid with both types 0 is ignored: no state change, no response.
  - WAIT: req_ready=0. Counter runs 1..WAIT_CYCLES, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle. Store bytes are committed to memory on the edge entering RESP; load data is sampled on that same edge. Next state is IDLE.
- Latency: a request accepted at edge T produces resp_valid high in the cycle following edge T+WAIT_CYCLES+1.
- req_ready is low in RESP. Back-to-back accepts are therefore spaced WAIT_CYCLES+2 cycles apart.
- There is no response backpressure; the core must be able to take resp_valid on any cycle.
- Byte order is little-endian.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - SB writes byte addr. SH writes addr..addr+1. SW writes addr..addr+3.
- Read and write both nonzero: the store is performed and resp_rdata=0.
- Stores: resp_rdata=0.
- Address arithmetic wraps modulo 2**ADDR_W.
- Reset asserted mid-transaction aborts it. An uncommitted store is dropped (the memory is cleared anyway) and no response is issued.
- Inputs change while busy: ignored, because the request was latched at accept.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]!=0, and LW/SW with addr[1:0]!=0, are misaligned.
  - Misaligned accesses keep full latency.
  - resp_err=1 with resp_valid.
  - Memory is not written; resp_rdata=0.
- Undefined:
  - The address is aligned down: low bit cleared for half-word, low 2 bits for word.
  - The access is performed.
  - resp_err is tied 0.

Decomposition:
- Shared package dmem_pkg holds:
  - Load/store type encodings (LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU; ST_NONE, ST_B, ST_H, ST_W).
  - FSM state encodings.
  - The alignment-check function.
- One natural sub-module, dmem_lane_fmt: combinational byte-enable generation, store-data lane placement and load extension.
- The FSM, counter and byte array stay in dmem_responder.

Test Plan:
- Reset then idle:
  - rst=0 for 2 cycles, then rst=1 → req_ready=1, resp_valid=0, busy=0.
  - An LW from 0x10 then returns 0x00000000.
- SW then LW, WAIT_CYCLES=2:
  - SW 0xDEADBEEF at 0x20 accepted at edge T → resp_valid in the cycle after T+3.
  - LW 0x20 → resp_rdata=0xDEADBEEF.
- Byte lanes:
  - SW 0x80FF7F01 at 0x40.
  - LB 0x43 → 0xFFFFFF80. LBU 0x43 → 0x00000080.
  - LH 0x40 → 0x00007F01. LHU 0x42 → 0x000080FF.
  - SB 0xAA at 0x41 then LW 0x40 → 0x80FFAA01.
- Handshake:
  - req_valid held high with back-to-back LWs → req_ready low during WAIT and RESP.
  - Second accept occurs exactly 4 cycles after the first.
  - A request with read=0 and write=0 produces no resp_valid.
- Reset mid-operation:
  - SW 0x12345678 at 0x08, rst=0 during WAIT → no resp_valid.
  - After release, LW 0x08 → 0x00000000.
- Misalign:
  - LW 0x21 with data 0xDEADBEEF at 0x20.
  - With DMEM_MISALIGN_TRAP_EN → resp_err=1, resp_rdata=0.
  - Without it → resp_err=0, resp_rdata=0xDEADBEEF.
  - SH 0xBEEF at 0x31 with the macro leaves LW 0x30 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared encodings and helpers for the data-memory responder.
//   ld_e     : load type as presented on req_read (6/7 decode to LD_NONE)
//   st_e     : store type as presented on req_write
//   state_e  : responder FSM states
//   decode_ld, access_mask, is_misaligned : request decode / alignment helpers
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5
  } ld_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_B    = 2'd1,
    ST_H    = 2'd2,
    ST_W    = 2'd3
  } st_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic ld_e decode_ld(input logic [2:0] code);
    case (code)
      3'd1:    return LD_B;
      3'd2:    return LD_H;
      3'd3:    return LD_W;
      3'd4:    return LD_BU;
      3'd5:    return LD_HU;
      default: return LD_NONE;
    endcase
  endfunction

  // Low address bits that must be zero for the access width. When a request
  // carries both a load and a store, the store is what gets performed, so its
  // width governs.
  function automatic logic [1:0] access_mask(input ld_e ld, input st_e st);
    if (st != ST_NONE) begin
      case (st)
        ST_H:    return 2'b01;
        ST_W:    return 2'b11;
        default: return 2'b00;
      endcase
    end
    case (ld)
      LD_H, LD_HU: return 2'b01;
      LD_W:        return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input ld_e ld, input st_e st,
                                         input logic [1:0] addr_lo);
    return |(addr_lo & access_mask(ld, st));
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt
// Combinational lane logic relative to an aligned base address.
//   ld_i     : load type
//   st_i     : store type
//   wdata_i  : store data (low bytes used)
//   raw_i    : bytes base+3..base+0, little-endian
//   be_o     : byte enables for base+0..base+3
//   wbytes_o : store bytes placed on lanes 0..3
//   rdata_o  : sign/zero-extended load result (0 for no load)
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  ld_e               ld_i,
  input  st_e               st_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [31:0]       raw_i,
  output logic [3:0]        be_o,
  output logic [31:0]       wbytes_o,
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    be_o = 4'b0000;
    case (st_i)
      ST_B:    be_o = 4'b0001;
      ST_H:    be_o = 4'b0011;
      ST_W:    be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  assign wbytes_o = wdata_i[31:0];

  always_comb begin
    rdata_o = '0;
    case (ld_i)
      LD_B:    rdata_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
      LD_BU:   rdata_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
      LD_H:    rdata_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
      LD_HU:   rdata_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
      LD_W:    rdata_o = DATA_W'(raw_i);
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder with a byte array of 2**ADDR_W bytes.
//   clk, rst (sync, active-low)
//   req_valid/req_ready, req_addr, req_read, req_write, req_wdata : request
//   resp_valid, resp_rdata, resp_err : one-cycle response
//   busy : transaction in flight
// Optional: DMEM_MISALIGN_TRAP_EN -- misaligned half/word accesses complete
// with resp_err=1 and no memory effect; otherwise addresses are aligned down.
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | counting wait states
// S_RESP | access committed, response goes out on the next cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_read,
  input  logic [1:0]        req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  ld_e               ld_q;
  st_e               st_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ld_data_q;
  logic              err_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic [7:0]        mem_q [DEPTH];

  ld_e               req_ld;
  st_e               req_st;
  logic              accept;
  logic              commit;
  ld_e               cur_ld;
  st_e               cur_st;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] cur_base;
  logic              cur_err;
  logic [ADDR_W-1:0] byte_addr [4];
  logic [31:0]       raw;
  logic [3:0]        be;
  logic [31:0]       wbytes;
  logic [DATA_W-1:0] fmt_rdata;

  assign req_ld = decode_ld(req_read);
  assign req_st = st_e'(req_write);
  assign accept = (state_q == S_IDLE) && req_valid
                  && ((req_ld != LD_NONE) || (req_st != ST_NONE));

  // With zero wait states the commit happens on the accept edge itself, so the
  // access must be taken straight from the request rather than the latches.
  assign cur_ld    = (state_q == S_IDLE) ? req_ld    : ld_q;
  assign cur_st    = (state_q == S_IDLE) ? req_st    : st_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  assign cur_base = cur_addr & ~{{(ADDR_W-2){1'b0}}, access_mask(cur_ld, cur_st)};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign cur_err = is_misaligned(cur_ld, cur_st, cur_addr[1:0]);
`else
  assign cur_err = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = cur_base + ADDR_W'(k);
    end
  end

  assign raw = {mem_q[byte_addr[3]], mem_q[byte_addr[2]],
                mem_q[byte_addr[1]], mem_q[byte_addr[0]]};

  dmem_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
    .ld_i     (cur_ld),
    .st_i     (cur_st),
    .wdata_i  (cur_wdata),
    .raw_i    (raw),
    .be_o     (be),
    .wbytes_o (wbytes),
    .rdata_o  (fmt_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_q != S_RESP) && (state_d == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      ld_q         <= LD_NONE;
      st_q         <= ST_NONE;
      wdata_q      <= '0;
      ld_data_q    <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        ld_q    <= req_ld;
        st_q    <= req_st;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q     <= cur_err;
        ld_data_q <= ((cur_st == ST_NONE) && !cur_err) ? fmt_rdata : '0;
        if ((cur_st != ST_NONE) && !cur_err) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) mem_q[byte_addr[k]] <= wbytes[8*k +: 8];
          end
        end
      end
      resp_valid_q <= (state_q == S_RESP);
      resp_rdata_q <= (state_q == S_RESP) ? ld_data_q : '0;
      resp_err_q   <= (state_q == S_RESP) && err_q;
    end
  end

  assign req_ready  = rst && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = 8'h00;
  logic [2:0]  req_read = 3'd0;
  logic [1:0]  req_write = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    if (resp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check("resp_valid_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive a request at a negedge where the DUT is ready; it is accepted at the
  // next posedge, and the response is visible at the negedge W+2 cycles later.
  task automatic issue(input logic [2:0] rd, input logic [1:0] wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input bit hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_read  = rd;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    e.rdata = er;
    e.err   = ee;
    e.due   = cyc + W + 2;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_read  = 3'($urandom_range(0, 7));
      req_write = 2'($urandom_range(0, 3));
      req_addr  = 8'($urandom);
      req_wdata = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'd3, 2'd0, 8'h10, 32'h0,        32'h00000000, 1'b0};
    tbl[1]  = '{3'd0, 2'd3, 8'h20, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[2]  = '{3'd3, 2'd0, 8'h20, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3]  = '{3'd0, 2'd3, 8'h40, 32'h80FF7F01, 32'h00000000, 1'b0};
    tbl[4]  = '{3'd1, 2'd0, 8'h43, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[5]  = '{3'd4, 2'd0, 8'h43, 32'h0,        32'h00000080, 1'b0};
    tbl[6]  = '{3'd2, 2'd0, 8'h40, 32'h0,        32'h00007F01, 1'b0};
    tbl[7]  = '{3'd5, 2'd0, 8'h42, 32'h0,        32'h000080FF, 1'b0};
    tbl[8]  = '{3'd0, 2'd1, 8'h41, 32'h123456AA, 32'h00000000, 1'b0};
    tbl[9]  = '{3'd3, 2'd0, 8'h40, 32'h0,        32'h80FFAA01, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[10] = '{3'd3, 2'd0, 8'h21, 32'h0,        32'h00000000, 1'b1};
    tbl[11] = '{3'd0, 2'd2, 8'h31, 32'h0000BEEF, 32'h00000000, 1'b1};
    tbl[12] = '{3'd3, 2'd0, 8'h30, 32'h0,        32'h00000000, 1'b0};
`else
    tbl[10] = '{3'd3, 2'd0, 8'h21, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[11] = '{3'd0, 2'd2, 8'h31, 32'h0000BEEF, 32'h00000000, 1'b0};
    tbl[12] = '{3'd3, 2'd0, 8'h30, 32'h0,        32'h0000BEEF, 1'b0};
`endif
    tbl[13] = '{3'd3, 2'd3, 8'h50, 32'h11223344, 32'h00000000, 1'b0};
    tbl[14] = '{3'd3, 2'd0, 8'h50, 32'h0,        32'h11223344, 1'b0};
    tbl[15] = '{3'd2, 2'd0, 8'h42, 32'h0,        32'hFFFF80FF, 1'b0};

    // Reset, then idle outputs.
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    check("busy_in_reset", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("resp_valid_after_reset", 32'(resp_valid), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("rdata_after_reset", resp_rdata, 32'd0);
    check("err_after_reset", 32'(resp_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].er, tbl[i].ee, 1'b0);
      drain();
    end

    // Back-to-back loads with req_valid held high.
    issue(3'd3, 2'd0, 8'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      check("ready_low_in_flight", 32'(req_ready), 32'd0);
      check("busy_in_flight", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("ready_high_for_second", 32'(req_ready), 32'd1);
    if (req_ready === 1'b1) begin
      exp_t e;
      req_addr  = 8'h40;
      e.rdata = 32'h80FFAA01;
      e.err   = 1'b0;
      e.due   = cyc + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // A request with no load or store must be ignored.
    req_valid = 1'b1;
    req_read  = 3'd0;
    req_write = 2'd0;
    req_addr  = 8'h20;
    repeat (5) begin
      @(negedge clk);
      check("null_req_busy", 32'(busy), 32'd0);
      check("null_req_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a store: no response, store dropped.
    issue(3'd0, 2'd3, 8'h08, 32'h12345678, 32'h0, 1'b0, 1'b0);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("ready_during_abort", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("busy_after_abort", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(3'd3, 2'd0, 8'h08, 32'h0, 32'h00000000, 1'b0, 1'b0);
    drain();
    issue(3'd3, 2'd0, 8'h20, 32'h0, 32'h00000000, 1'b0, 1'b0);
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
